// File: rtl/riscv_pkg.sv
// Shared constants and types for the ID/EX pipeline slice.
package riscv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    // What the ID/EX register does at the next rising edge, highest priority last.
    typedef enum logic [1:0] {
        EX_ADVANCE = 2'd0,
        EX_BUBBLE  = 2'd1,
        EX_HOLD    = 2'd2,
        EX_FLUSH   = 2'd3
    } ex_action_e;

endpackage

// File: rtl/operand_bypass.sv
// Operand select for one source register: x0 reads zero, a same-cycle
// write-back to the register wins over the register-file read data.
module operand_bypass
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = riscv_pkg::XLEN
) (
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [XLEN-1:0]       rf_data,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  wb_en,
    output logic [XLEN-1:0]       op
);

    // Zero-cycle bypass mux.
    always_comb begin
        op = rf_data;
        if (rs_addr == ZERO_REG) begin
            op = '0;
        end else if (wb_en && (wb_addr == rs_addr)) begin
            op = wb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand bypass, load-use bubble insertion,
// back-pressure hold with write-back refresh, flush, and a stall counter.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = riscv_pkg::XLEN
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic [XLEN-1:0]       id_imm,
    input  logic [XLEN-1:0]       id_pc,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic [XLEN-1:0]       rf_read_data_1,
    input  logic [XLEN-1:0]       rf_read_data_2,
    input  logic [REG_ADDR_W-1:0] wb_write_addr,
    input  logic [XLEN-1:0]       wb_write_data,
    input  logic                  wb_write_enable,
    input  logic                  flush,
    input  logic                  ex_ready,
    output logic                  id_stall,
    output logic                  ex_valid,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic [REG_ADDR_W-1:0] ex_rs1_addr,
    output logic [REG_ADDR_W-1:0] ex_rs2_addr,
    output logic [REG_ADDR_W-1:0] ex_rd_addr,
    output logic [XLEN-1:0]       ex_rs1_data,
    output logic [XLEN-1:0]       ex_rs2_data,
    output logic [XLEN-1:0]       ex_imm,
    output logic [XLEN-1:0]       ex_pc,
    output logic [31:0]           stall_count
);

    logic                  ex_valid_q,     ex_valid_d;
    logic                  ex_reg_write_q, ex_reg_write_d;
    logic                  ex_mem_read_q,  ex_mem_read_d;
    logic [REG_ADDR_W-1:0] ex_rs1_addr_q,  ex_rs1_addr_d;
    logic [REG_ADDR_W-1:0] ex_rs2_addr_q,  ex_rs2_addr_d;
    logic [REG_ADDR_W-1:0] ex_rd_addr_q,   ex_rd_addr_d;
    logic [XLEN-1:0]       ex_rs1_data_q,  ex_rs1_data_d;
    logic [XLEN-1:0]       ex_rs2_data_q,  ex_rs2_data_d;
    logic [XLEN-1:0]       ex_imm_q,       ex_imm_d;
    logic [XLEN-1:0]       ex_pc_q,        ex_pc_d;
    logic [31:0]           stall_count_q,  stall_count_d;

    logic [XLEN-1:0] rs1_op;
    logic [XLEN-1:0] rs2_op;
    logic            hazard;
    logic            hold;
    ex_action_e      action;

    operand_bypass #(.XLEN(XLEN)) u_bypass_rs1 (
        .rs_addr (id_rs1_addr),
        .rf_data (rf_read_data_1),
        .wb_addr (wb_write_addr),
        .wb_data (wb_write_data),
        .wb_en   (wb_write_enable),
        .op      (rs1_op)
    );

    operand_bypass #(.XLEN(XLEN)) u_bypass_rs2 (
        .rs_addr (id_rs2_addr),
        .rf_data (rf_read_data_2),
        .wb_addr (wb_write_addr),
        .wb_data (wb_write_data),
        .wb_en   (wb_write_enable),
        .op      (rs2_op)
    );

    // Hazard detection and next-edge action: flush > hold > hazard > advance.
    always_comb begin
        hazard = id_valid && ex_valid_q && ex_mem_read_q && (ex_rd_addr_q != ZERO_REG) &&
                 ((ex_rd_addr_q == id_rs1_addr) || (ex_rd_addr_q == id_rs2_addr));
        hold     = ex_valid_q && !ex_ready;
        id_stall = hazard || hold;

        action = EX_ADVANCE;
        if (flush) begin
            action = EX_FLUSH;
        end else if (hold) begin
            action = EX_HOLD;
        end else if (hazard) begin
            action = EX_BUBBLE;
        end
    end

    // Next-state values for every ID/EX register and the stall counter.
    always_comb begin
        ex_valid_d     = ex_valid_q;
        ex_reg_write_d = ex_reg_write_q;
        ex_mem_read_d  = ex_mem_read_q;
        ex_rs1_addr_d  = ex_rs1_addr_q;
        ex_rs2_addr_d  = ex_rs2_addr_q;
        ex_rd_addr_d   = ex_rd_addr_q;
        ex_rs1_data_d  = ex_rs1_data_q;
        ex_rs2_data_d  = ex_rs2_data_q;
        ex_imm_d       = ex_imm_q;
        ex_pc_d        = ex_pc_q;
        stall_count_d  = stall_count_q;

        unique case (action)
            EX_FLUSH, EX_BUBBLE: begin
                ex_valid_d     = 1'b0;
                ex_reg_write_d = 1'b0;
                ex_mem_read_d  = 1'b0;
            end
            EX_HOLD: begin
                // A write-back landing on a held source register must not be lost.
                if (wb_write_enable && (wb_write_addr != ZERO_REG) &&
                    (wb_write_addr == ex_rs1_addr_q)) begin
                    ex_rs1_data_d = wb_write_data;
                end
                if (wb_write_enable && (wb_write_addr != ZERO_REG) &&
                    (wb_write_addr == ex_rs2_addr_q)) begin
                    ex_rs2_data_d = wb_write_data;
                end
            end
            default: begin
                ex_valid_d     = id_valid;
                ex_reg_write_d = id_valid && id_reg_write;
                ex_mem_read_d  = id_valid && id_mem_read;
                ex_rs1_addr_d  = id_rs1_addr;
                ex_rs2_addr_d  = id_rs2_addr;
                ex_rd_addr_d   = id_rd_addr;
                ex_rs1_data_d  = rs1_op;
                ex_rs2_data_d  = rs2_op;
                ex_imm_d       = id_imm;
                ex_pc_d        = id_pc;
            end
        endcase

        if (id_stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    // All state, asynchronously cleared by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid_q     <= 1'b0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            ex_rs1_addr_q  <= '0;
            ex_rs2_addr_q  <= '0;
            ex_rd_addr_q   <= '0;
            ex_rs1_data_q  <= '0;
            ex_rs2_data_q  <= '0;
            ex_imm_q       <= '0;
            ex_pc_q        <= '0;
            stall_count_q  <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_reg_write_q <= ex_reg_write_d;
            ex_mem_read_q  <= ex_mem_read_d;
            ex_rs1_addr_q  <= ex_rs1_addr_d;
            ex_rs2_addr_q  <= ex_rs2_addr_d;
            ex_rd_addr_q   <= ex_rd_addr_d;
            ex_rs1_data_q  <= ex_rs1_data_d;
            ex_rs2_data_q  <= ex_rs2_data_d;
            ex_imm_q       <= ex_imm_d;
            ex_pc_q        <= ex_pc_d;
            stall_count_q  <= stall_count_d;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_reg_write = ex_reg_write_q;
    assign ex_mem_read  = ex_mem_read_q;
    assign ex_rs1_addr  = ex_rs1_addr_q;
    assign ex_rs2_addr  = ex_rs2_addr_q;
    assign ex_rd_addr   = ex_rd_addr_q;
    assign ex_rs1_data  = ex_rs1_data_q;
    assign ex_rs2_data  = ex_rs2_data_q;
    assign ex_imm       = ex_imm_q;
    assign ex_pc        = ex_pc_q;
    assign stall_count  = stall_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, reset and
// saturation sequences, then randomized traffic against a reference model.
module tb_id_ex_stage;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            id_valid;
    logic [4:0]      id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [XLEN-1:0] id_imm, id_pc;
    logic            id_reg_write, id_mem_read;
    logic [XLEN-1:0] rf_read_data_1, rf_read_data_2;
    logic [4:0]      wb_write_addr;
    logic [XLEN-1:0] wb_write_data;
    logic            wb_write_enable;
    logic            flush, ex_ready;
    logic            id_stall;
    logic            ex_valid, ex_reg_write, ex_mem_read;
    logic [4:0]      ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
    logic [XLEN-1:0] ex_rs1_data, ex_rs2_data, ex_imm, ex_pc;
    logic [31:0]     stall_count;

    int n_checks = 0;
    int n_errors = 0;

    id_ex_stage #(.XLEN(XLEN)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_valid        (id_valid),
        .id_rs1_addr     (id_rs1_addr),
        .id_rs2_addr     (id_rs2_addr),
        .id_rd_addr      (id_rd_addr),
        .id_imm          (id_imm),
        .id_pc           (id_pc),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .rf_read_data_1  (rf_read_data_1),
        .rf_read_data_2  (rf_read_data_2),
        .wb_write_addr   (wb_write_addr),
        .wb_write_data   (wb_write_data),
        .wb_write_enable (wb_write_enable),
        .flush           (flush),
        .ex_ready        (ex_ready),
        .id_stall        (id_stall),
        .ex_valid        (ex_valid),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .ex_rs1_addr     (ex_rs1_addr),
        .ex_rs2_addr     (ex_rs2_addr),
        .ex_rd_addr      (ex_rd_addr),
        .ex_rs1_data     (ex_rs1_data),
        .ex_rs2_data     (ex_rs2_data),
        .ex_imm          (ex_imm),
        .ex_pc           (ex_pc),
        .stall_count     (stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0;
        id_imm = 0; id_pc = 0; id_reg_write = 0; id_mem_read = 0;
        rf_read_data_1 = 0; rf_read_data_2 = 0;
        wb_write_addr = 0; wb_write_data = 0; wb_write_enable = 0;
        flush = 0; ex_ready = 1;
    endtask

    // Directed vector: inputs for one cycle, expected id_stall before the edge,
    // expected registered outputs after it.
    typedef struct {
        logic        v;
        logic [4:0]  rs1, rs2, rd;
        logic        rw, mr;
        logic [31:0] rf1, rf2;
        logic        wbe;
        logic [4:0]  wba;
        logic [31:0] wbd;
        logic        fl, rdy;
        logic        e_stall, e_valid, e_rw, e_mr;
        logic        e_chk;
        logic [31:0] e_rs1d, e_rs2d;
        logic [4:0]  e_rd;
        logic [31:0] e_pc;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[9];

    // Reference model of the ID/EX contents.
    typedef struct {
        logic        valid, rw, mr;
        logic [4:0]  rs1a, rs2a, rda;
        logic [31:0] rs1d, rs2d, imm, pc;
    } ex_model_t;

    ex_model_t       m;
    longint unsigned m_cnt;

    function automatic logic [31:0] reg_value(input logic [4:0] a, input logic [31:0] rf,
                                              input logic we, input logic [4:0] wa,
                                              input logic [31:0] wd);
        if (a == 0) return 32'd0;
        if (we && wa == a) return wd;
        return rf;
    endfunction

    function automatic logic model_hazard();
        return id_valid && m.valid && m.mr && m.rda != 0 &&
               (m.rda == id_rs1_addr || m.rda == id_rs2_addr);
    endfunction

    function automatic logic model_stall();
        return model_hazard() || (m.valid && !ex_ready);
    endfunction

    task automatic model_edge();
        logic hz, hd;
        hz = model_hazard();
        hd = m.valid && !ex_ready;
        if ((hz || hd) && m_cnt < 64'hFFFF_FFFF) m_cnt++;
        if (flush) begin
            m.valid = 0; m.rw = 0; m.mr = 0;
        end else if (hd) begin
            if (wb_write_enable && wb_write_addr != 0 && wb_write_addr == m.rs1a) m.rs1d = wb_write_data;
            if (wb_write_enable && wb_write_addr != 0 && wb_write_addr == m.rs2a) m.rs2d = wb_write_data;
        end else if (hz) begin
            m.valid = 0; m.rw = 0; m.mr = 0;
        end else begin
            m.valid = id_valid;
            m.rw    = id_valid && id_reg_write;
            m.mr    = id_valid && id_mem_read;
            m.rs1a  = id_rs1_addr;
            m.rs2a  = id_rs2_addr;
            m.rda   = id_rd_addr;
            m.rs1d  = reg_value(id_rs1_addr, rf_read_data_1, wb_write_enable, wb_write_addr, wb_write_data);
            m.rs2d  = reg_value(id_rs2_addr, rf_read_data_2, wb_write_enable, wb_write_addr, wb_write_data);
            m.imm   = id_imm;
            m.pc    = id_pc;
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " ex_valid"}, 192'(ex_valid), 192'(0));
        chk({tag, " ex_ctrl"}, 192'({ex_reg_write, ex_mem_read}), 192'(0));
        chk({tag, " ex_payload"},
            192'({ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_rs1_data, ex_rs2_data, ex_imm, ex_pc}), 192'(0));
        chk({tag, " stall_count"}, 192'(stall_count), 192'(0));
        chk({tag, " id_stall"}, 192'(id_stall), 192'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 0;
        #2;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1;
        m = '{default: '0};
        m_cnt = 0;
    endtask

    initial begin
        int unsigned hold_run;
        idle_inputs();
        reset = 0;
        #1;
        check_all_zero("async_reset_initial");
        @(negedge clk);
        @(negedge clk);
        reset = 1;

        // ---------------- directed vector table ----------------
        //          v rs1 rs2 rd rw mr rf1           rf2           wbe wba wbd         fl rdy | stall valid rw mr chk rs1d          rs2d          rd pc  cnt
        vecs[0] = '{1, 5, 0, 1, 1, 0, 32'h11,       32'h99,       1, 5, 32'hAB,       0, 1,  0, 1, 1, 0, 1, 32'hAB,  32'h0,  1, 0,  0};
        vecs[1] = '{1, 0, 2, 7, 1, 1, 32'hFFFF_FFFF,32'h22,       1, 0, 32'h77,       0, 1,  0, 1, 1, 1, 1, 32'h0,   32'h22, 7, 4,  0};
        vecs[2] = '{1, 3, 7, 4, 1, 0, 32'h33,       32'h44,       0, 0, 32'h0,        0, 1,  1, 0, 0, 0, 0, 32'h0,   32'h0,  0, 0,  1};
        vecs[3] = '{1, 3, 7, 4, 1, 0, 32'h33,       32'h44,       0, 0, 32'h0,        0, 1,  0, 1, 1, 0, 1, 32'h33,  32'h44, 4, 12, 1};
        vecs[4] = '{1, 3, 6, 3, 1, 1, 32'h31,       32'h66,       0, 0, 32'h0,        0, 1,  0, 1, 1, 1, 1, 32'h31,  32'h66, 3, 16, 1};
        vecs[5] = '{1, 3, 9, 8, 1, 0, 32'h1,        32'h2,        1, 3, 32'h55,       0, 0,  1, 1, 1, 1, 1, 32'h55,  32'h66, 3, 16, 2};
        vecs[6] = '{1, 3, 9, 8, 1, 0, 32'h1,        32'h2,        0, 3, 32'h77,       0, 0,  1, 1, 1, 1, 1, 32'h55,  32'h66, 3, 16, 3};
        vecs[7] = '{1, 3, 9, 8, 1, 0, 32'h1,        32'h2,        0, 0, 32'h0,        1, 0,  1, 0, 0, 0, 0, 32'h0,   32'h0,  0, 0,  4};
        vecs[8] = '{0, 1, 2, 9, 1, 1, 32'h1,        32'h2,        0, 0, 32'h0,        0, 1,  0, 0, 0, 0, 0, 32'h0,   32'h0,  0, 0,  4};

        foreach (vecs[i]) begin
            @(negedge clk);
            id_valid = vecs[i].v; id_rs1_addr = vecs[i].rs1; id_rs2_addr = vecs[i].rs2;
            id_rd_addr = vecs[i].rd; id_reg_write = vecs[i].rw; id_mem_read = vecs[i].mr;
            id_imm = 32'(i) + 32'h100; id_pc = 32'(i) * 4;
            rf_read_data_1 = vecs[i].rf1; rf_read_data_2 = vecs[i].rf2;
            wb_write_enable = vecs[i].wbe; wb_write_addr = vecs[i].wba; wb_write_data = vecs[i].wbd;
            flush = vecs[i].fl; ex_ready = vecs[i].rdy;
            #1;
            chk($sformatf("vec%0d id_stall", i), 192'(id_stall), 192'(vecs[i].e_stall));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d ex_valid", i), 192'(ex_valid), 192'(vecs[i].e_valid));
            chk($sformatf("vec%0d ex_ctrl", i), 192'({ex_reg_write, ex_mem_read}),
                192'({vecs[i].e_rw, vecs[i].e_mr}));
            chk($sformatf("vec%0d stall_count", i), 192'(stall_count), 192'(vecs[i].e_cnt));
            if (vecs[i].e_chk) begin
                chk($sformatf("vec%0d payload", i), 192'({ex_rs1_data, ex_rs2_data, ex_rd_addr, ex_pc}),
                    192'({vecs[i].e_rs1d, vecs[i].e_rs2d, vecs[i].e_rd, vecs[i].e_pc}));
            end
        end

        // ------------- reset mid-hold, then first edge advances -------------
        @(negedge clk);
        idle_inputs();
        id_valid = 1; id_rs1_addr = 4; id_rd_addr = 6; id_reg_write = 1;
        rf_read_data_1 = 32'hCAFE; id_pc = 32'h40;
        @(negedge clk);
        ex_ready = 0; id_valid = 0;
        @(posedge clk);
        #1;
        chk("hold_setup ex_valid", 192'(ex_valid), 192'(1));
        chk("hold_setup id_stall", 192'(id_stall), 192'(1));
        #2;
        reset = 0;
        #1;
        check_all_zero("reset_mid_hold");
        @(negedge clk);
        reset = 1;
        id_valid = 1; id_rs1_addr = 2; id_rd_addr = 5; id_reg_write = 1;
        rf_read_data_1 = 32'h1234; id_pc = 32'h80;
        #1;
        chk("post_reset id_stall", 192'(id_stall), 192'(0));
        @(posedge clk);
        #1;
        chk("post_reset advance", 192'({ex_valid, ex_rd_addr, ex_rs1_data, ex_pc}),
            192'({1'b1, 5'd5, 32'h1234, 32'h80}));

        // ------------- stall counter saturation -------------
        @(negedge clk);
        id_valid = 0;
        ex_ready = 0;
        force dut.stall_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_count_q;
        #1;
        chk("sat preload", 192'(stall_count), 192'(32'hFFFF_FFFE));
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("sat cycle%0d", k), 192'(stall_count), 192'(32'hFFFF_FFFF));
        end

        // ------------- randomized traffic vs. reference model -------------
        idle_inputs();
        do_reset();
        hold_run = 0;
        for (int c = 0; c < 3000; c++) begin
            id_valid        = ($urandom_range(0, 9) < 8);
            id_rs1_addr     = 5'($urandom_range(0, 7));
            id_rs2_addr     = 5'($urandom_range(0, 7));
            id_rd_addr      = 5'($urandom_range(0, 7));
            id_reg_write    = 1'($urandom);
            id_mem_read     = 1'($urandom);
            id_imm          = $urandom;
            id_pc           = $urandom;
            rf_read_data_1  = $urandom;
            rf_read_data_2  = $urandom;
            wb_write_enable = 1'($urandom);
            wb_write_addr   = 5'($urandom_range(0, 7));
            wb_write_data   = $urandom;
            flush           = ($urandom_range(0, 15) == 0);
            ex_ready        = (hold_run > 4) || ($urandom_range(0, 3) != 0);
            hold_run        = ex_ready ? 0 : hold_run + 1;
            #1;
            chk("rand id_stall", 192'(id_stall), 192'(model_stall()));
            @(posedge clk);
            model_edge();
            #1;
            chk("rand ctrl", 192'({ex_valid, ex_reg_write, ex_mem_read}), 192'({m.valid, m.rw, m.mr}));
            chk("rand stall_count", 192'(stall_count), 192'(m_cnt[31:0]));
            if (m.valid) begin
                chk("rand payload",
                    192'({ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_rs1_data, ex_rs2_data, ex_imm, ex_pc}),
                    192'({m.rs1a, m.rs2a, m.rda, m.rs1d, m.rs2d, m.imm, m.pc}));
            end
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous, active-low; one clock domain only.
REQ-004 id_valid  in  1  decode slot holds a real instruction.
REQ-005 id_rs1_addr, id_rs2_addr, id_rd_addr  in  5 each  decoded register indices.
REQ-006 id_imm, id_pc  in  XLEN each  decoded immediate, instruction PC.
REQ-007 id_reg_write, id_mem_read  in  1 each  decoded control bits.
REQ-008 rf_read_data_1, rf_read_data_2  in  XLEN each  register-file combinational read data for id_rs1_addr/id_rs2_addr.
REQ-009 wb_write_addr  in  5; wb_write_data  in  XLEN; wb_write_enable  in  1  same signals driving the register-file write port.
REQ-010 flush  in  1  kill younger instruction (branch/jump redirect).
REQ-011 ex_ready  in  1  execute stage accepts current ex_* contents this cycle.
REQ-012 id_stall  out  1  hold IF/ID this cycle (combinational).
REQ-013 ex_valid, ex_reg_write, ex_mem_read  out  1 each; ex_rs1_addr, ex_rs2_addr, ex_rd_addr  out  5 each; ex_rs1_data, ex_rs2_data, ex_imm, ex_pc  out  XLEN each  registered ID/EX contents.
REQ-014 stall_count  out  32  saturating count of cycles with id_stall=1.

Function
REQ-015 Operand bypass: op = 0 if addr==0; else wb_write_data if wb_write_enable && wb_write_addr==addr; else rf read data; applied to rs1 and rs2 independently.
REQ-016 hazard = id_valid && ex_valid && ex_mem_read && ex_rd_addr!=0 && (ex_rd_addr==id_rs1_addr || ex_rd_addr==id_rs2_addr).
REQ-017 hold = ex_valid && !ex_ready; id_stall = hazard || hold.
REQ-018 Priority at each rising edge: flush > hold > hazard > advance.
REQ-019 flush: ex_valid, ex_reg_write, ex_mem_read <= 0 regardless of ex_ready; other fields don't-care.
REQ-020 hold (no flush): all ex_* registers keep value, except REQ-021 refresh.
REQ-021 Refresh while holding: if wb_write_enable && wb_write_addr!=0 && wb_write_addr==ex_rs1_addr, ex_rs1_data <= wb_write_data; same for rs2.
REQ-022 hazard (no flush, no hold): insert bubble — ex_valid, ex_reg_write, ex_mem_read <= 0; IF/ID held via id_stall.
REQ-023 advance: ex_valid <= id_valid; payload <= decode fields and bypassed operands; when id_valid=0, ex_reg_write and ex_mem_read <= 0.
REQ-024 Latency: one cycle from id_* to ex_*; bypass is zero-cycle combinational.
REQ-025 stall_count increments by 1 per cycle with id_stall=1, saturates at 0xFFFF_FFFF, never wraps.
REQ-026 Writes to x0 never bypass or refresh; x0 operands always read 0.

Reset
REQ-027 reset=0 SHALL immediately clear every ex_* register and stall_count to 0, independent of clk.
REQ-028 id_stall SHALL be 0 during and after reset until state re-enables it.
REQ-029 Reset asserted mid-hold or mid-bubble discards the held instruction; first post-reset edge behaves as advance.

Structure
REQ-030 Shared package riscv_pkg SHALL hold XLEN, REG_ADDR_W=5, ZERO_REG=0.
REQ-031 Bypass mux SHALL be sub-module operand_bypass, instantiated twice (rs1, rs2).
REQ-032 Single always block with async reset for all state; no latches.

Verification
REQ-033 rs1=5, rf=0x11, wb_en=1 wb_addr=5 wb_data=0xAB, advance -> ex_rs1_data=0xAB next cycle.
REQ-034 ex holds lw rd=7; id rs2=7 -> id_stall=1, next ex_valid=0, stall_count +1; following cycle instruction issues.
REQ-035 ex_valid=1, ex_ready=0 two cycles, wb writes 0x55 to ex_rs1_addr=3 -> ex_rs1_data=0x55, other fields unchanged, id_stall=1.
REQ-036 flush=1 together with hold and hazard -> ex_valid=0 next cycle.
REQ-037 rs1=0, rf=0xFFFF_FFFF, wb_en=1 wb_addr=0 -> ex_rs1_data=0.
REQ-038 reset=0 asynchronously mid-hold -> all ex_* and stall_count 0 before next edge; preload stall_count=0xFFFF_FFFE, stall 3 cycles -> 0xFFFF_FFFF.
